// File: rtl/cfeb_data_rcvr.sv
// CFEB readout link receiver: frames 16-bit pushed words into fixed-size blocks, checks word
// count and CRC, and writes tagged words {blk_err, end_flag, word} to a downstream FIFO.
module cfeb_data_rcvr #(
    parameter int unsigned Words = 97,
    parameter int unsigned Tmo   = 255,
    parameter int unsigned Tmr   = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [15:0] din_i,
    input  logic        lpush_b_i,
    input  logic        endword_i,
    input  logic        dataavail_i,
    input  logic        overlap_i,
    input  logic        fifo_full_i,
    input  logic        err_clr_i,
    output logic        fifo_we_o,
    output logic [17:0] fifo_data_o,
    output logic        blk_done_o,
    output logic        crc_err_o,
    output logic        wc_err_o,
    output logic        tmo_err_o,
    output logic        ovfl_err_o,
    output logic        ovlp_seen_o,
    output logic [7:0]  blk_cnt_o
);
    typedef enum logic [1:0] {StIdle, StWait, StRecv, StDone} state_e;

    localparam int unsigned      TcntW   = $clog2(Tmo + 1);
    localparam int unsigned      VecW    = 2 + 7 + 16 + 8 + TcntW;
    localparam logic [6:0]       WordsC  = 7'(Words);
    localparam logic [TcntW-1:0] TmoLast = TcntW'(Tmo - 1);
    localparam logic [TcntW-1:0] TcntOne = TcntW'(1);

    logic [15:0] din_q;
    logic        push_q, end_q, ovlp_q, dav_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            din_q  <= '0;
            push_q <= 1'b0;
            end_q  <= 1'b0;
            ovlp_q <= 1'b0;
            dav_q  <= 1'b0;
        end else begin
            din_q  <= din_i;
            push_q <= ~lpush_b_i;
            end_q  <= endword_i;
            ovlp_q <= overlap_i;
            dav_q  <= dataavail_i;
        end
    end

    // FSM state and counters travel as one vector so they can be stored once or triplicated.
    state_e           state_q, state_d;
    logic [6:0]       wcnt_q, wcnt_d;
    logic [15:0]      crc_q, crc_d;
    logic [7:0]       blk_cnt_q, blk_cnt_d;
    logic [TcntW-1:0] tcnt_q, tcnt_d;
    logic [VecW-1:0]  vec_d, vec_v;

    assign vec_d = {state_d, wcnt_d, crc_d, blk_cnt_d, tcnt_d};
    assign state_q = state_e'(vec_v[VecW-1 -: 2]);
    assign {wcnt_q, crc_q, blk_cnt_q, tcnt_q} = vec_v[VecW-3:0];

    if (Tmr != 0) begin : g_tmr
        logic [VecW-1:0] c0_q, c1_q, c2_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                c0_q <= '0;
                c1_q <= '0;
                c2_q <= '0;
            end else begin
                c0_q <= vec_d;
                c1_q <= vec_d;
                c2_q <= vec_d;
            end
        end
        // Bitwise majority: a single upset copy is outvoted and rewritten on the next edge.
        assign vec_v = (c0_q & c1_q) | (c0_q & c2_q) | (c1_q & c2_q);
    end else begin : g_single
        logic [VecW-1:0] c0_q;
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) c0_q <= '0;
            else         c0_q <= vec_d;
        end
        assign vec_v = c0_q;
    end

    logic [15:0] crc_base, crc_upd;
    logic [6:0]  wcnt_base, wcnt_inc;
    logic        ovlp_base, accept, write_due, dav_rise;
    logic [17:0] wdata;
    logic        crc_ev, wc_ev, tmo_ev;
    logic        ovlp_acc_q, ovlp_acc_d, ovlp_seen_q, ovlp_seen_d;
    logic        fifo_we_q;
    logic [17:0] fifo_data_q;
    logic        crc_err_q, wc_err_q, tmo_err_q, ovfl_err_q;

    assign dav_rise = dataavail_i & ~dav_q;
    assign crc_upd  = {crc_base[14:0], 1'b0} ^ (crc_base[15] ? 16'h1021 : 16'h0000) ^ din_q;
    assign wcnt_inc = wcnt_base + 7'd1;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        crc_d       = crc_q;
        blk_cnt_d   = blk_cnt_q;
        tcnt_d      = tcnt_q;
        ovlp_acc_d  = ovlp_acc_q;
        ovlp_seen_d = ovlp_seen_q;
        crc_base    = crc_q;
        wcnt_base   = wcnt_q;
        ovlp_base   = ovlp_acc_q;
        accept      = 1'b0;
        write_due   = 1'b0;
        wdata       = '0;
        crc_ev      = 1'b0;
        wc_ev       = 1'b0;
        tmo_ev      = 1'b0;
        unique case (state_q)
            StIdle, StDone: begin
                crc_base  = '0;
                wcnt_base = '0;
                ovlp_base = 1'b0;
                if (push_q) begin
                    accept = 1'b1;
                end else if (dav_rise) begin
                    state_d = StWait;
                    tcnt_d  = '0;
                end else begin
                    state_d = StIdle;
                end
            end
            StWait: begin
                crc_base  = '0;
                wcnt_base = '0;
                ovlp_base = 1'b0;
                if (push_q) begin
                    accept = 1'b1;
                end else if (tcnt_q == TmoLast) begin
                    tmo_ev  = 1'b1;
                    state_d = StIdle;
                end else begin
                    tcnt_d = tcnt_q + TcntOne;
                end
            end
            StRecv:  accept = push_q;
            default: state_d = StIdle;
        endcase

        if (accept) begin
            state_d    = StRecv;
            ovlp_acc_d = ovlp_base | ovlp_q;
            crc_d      = crc_base;
            wcnt_d     = wcnt_base;
            if (wcnt_base == WordsC) begin
                // Block already holds its full word count: extra words are dropped.
                wc_ev = 1'b1;
            end else begin
                wcnt_d    = wcnt_inc;
                write_due = 1'b1;
                if (end_q) begin
                    crc_ev = (din_q != crc_base);
                    wc_ev  = (wcnt_inc != WordsC);
                    wdata  = {crc_ev | wc_ev, 1'b1, din_q};
                end else begin
                    crc_d = crc_upd;
                    wdata = {2'b00, din_q};
                end
            end
            if (end_q) begin
                state_d     = StDone;
                blk_cnt_d   = blk_cnt_q + 8'd1;
                ovlp_seen_d = ovlp_base | ovlp_q;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_we_q   <= 1'b0;
            fifo_data_q <= '0;
            crc_err_q   <= 1'b0;
            wc_err_q    <= 1'b0;
            tmo_err_q   <= 1'b0;
            ovfl_err_q  <= 1'b0;
            ovlp_acc_q  <= 1'b0;
            ovlp_seen_q <= 1'b0;
        end else begin
            fifo_we_q <= write_due & ~fifo_full_i;
            if (write_due && !fifo_full_i) fifo_data_q <= wdata;
            crc_err_q   <= (crc_err_q & ~err_clr_i) | crc_ev;
            wc_err_q    <= (wc_err_q & ~err_clr_i) | wc_ev;
            tmo_err_q   <= (tmo_err_q & ~err_clr_i) | tmo_ev;
            ovfl_err_q  <= (ovfl_err_q & ~err_clr_i) | (write_due & fifo_full_i);
            ovlp_acc_q  <= ovlp_acc_d;
            ovlp_seen_q <= ovlp_seen_d;
        end
    end

    assign fifo_we_o   = fifo_we_q;
    assign fifo_data_o = fifo_data_q;
    assign blk_done_o  = (state_q == StDone);
    assign crc_err_o   = crc_err_q;
    assign wc_err_o    = wc_err_q;
    assign tmo_err_o   = tmo_err_q;
    assign ovfl_err_o  = ovfl_err_q;
    assign ovlp_seen_o = ovlp_seen_q;
    assign blk_cnt_o   = blk_cnt_q;

endmodule
